// File: rtl/aes_output_buffer.sv
// ============================================================================
//  Module   : aes_output_buffer
//  Purpose  : Block FIFO behind the AES round pipeline. It serializes each
//             128-bit result into four 32-bit stream words and raises an
//             early stall request.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_output_buffer #(
    parameter int DEPTH        = 16,
    parameter int TAG_W        = 4,
    parameter int STALL_MARGIN = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [127:0]                 in_data,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic                         in_decrypt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_data,
    output logic                         out_last,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         out_decrypt,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         stall_req,
    output logic                         overflow
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_occ_w  = $clog2(DEPTH+1);

    logic [127:0]        r_mem_data [DEPTH];
    logic [TAG_W-1:0]    r_mem_tag  [DEPTH];
    logic                r_mem_dec  [DEPTH];

    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_occ_w-1:0]  r_occ;
    logic [1:0]          r_wc;
    logic                r_overflow;

    logic                w_full;
    logic                w_hs;
    logic                w_final;
    logic                w_wr;
    logic                w_drop;
    logic [127:0]        w_head;
    logic [31:0]         w_word;

    assign out_valid = (r_occ != '0);
    assign w_full    = (r_occ == c_occ_w'(DEPTH));
    assign w_hs      = out_valid & out_ready;
    assign w_final   = w_hs & (r_wc == 2'd3);
    // A full FIFO still takes a block when its head leaves this same cycle.
    assign w_wr      = in_valid & (~w_full | w_final);
    assign w_drop    = in_valid & w_full & ~w_final;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_tag[r_wr_ptr]  <= in_tag;
            r_mem_dec[r_wr_ptr]  <= in_decrypt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_wc       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_hs) begin
                r_wc <= r_wc + 1'b1;
            end
            if (w_final) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_final})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head = r_mem_data[r_rd_ptr];

    always_comb begin
        w_word = '0;
        case (r_wc)
            2'd0:    w_word = w_head[127:96];
            2'd1:    w_word = w_head[95:64];
            2'd2:    w_word = w_head[63:32];
            default: w_word = w_head[31:0];
        endcase
    end

    // Head fields are gated so an empty buffer presents all-zero outputs.
    assign out_data    = out_valid ? w_word : '0;
    assign out_last    = out_valid & (r_wc == 2'd3);
    assign out_tag     = out_valid ? r_mem_tag[r_rd_ptr] : '0;
    assign out_decrypt = out_valid & r_mem_dec[r_rd_ptr];
    assign occupancy   = r_occ;
    assign stall_req   = (r_occ >= c_occ_w'(DEPTH - STALL_MARGIN));
    assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: doc/aes_output_buffer.md
# aes_output_buffer

Output-side buffer directly downstream of the AES round pipeline. Captures each 128-bit result block as it leaves the last round stage, stores it with its tag and direction flag in a FIFO, and serializes it as four 32-bit words over a valid/ready stream. The round pipeline has no backpressure, so the block raises an early stall request that the controller uses to stop issuing new blocks while results still in flight can always be absorbed.

## Interface
- DEPTH, 16: FIFO capacity in 128-bit blocks; power of two, at least 4.
- TAG_W, 4: width of the per-block tag carried alongside the data.
- STALL_MARGIN, 11: in-flight blocks the FIFO must still be able to absorb when a stall is requested; equals the pipeline depth (first round + 9 rounds + last round). Must be less than DEPTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  result block present on in_data this cycle.
- in_data  input  128  result block from the last round stage.
- in_tag  input  TAG_W  tag of the block.
- in_decrypt  input  1  1 = block was decrypted, 0 = encrypted.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  32  current word of the head block.
- out_last  output  1  current word is word 3 of its block.
- out_tag  output  TAG_W  tag of the head block.
- out_decrypt  output  1  direction flag of the head block.
- occupancy  output  $clog2(DEPTH+1)  number of stored blocks, including a partially sent head block.
- stall_req  output  1  high when (DEPTH - occupancy) <= STALL_MARGIN.
- overflow  output  1  sticky; a block was dropped.

## Operation
- Storage: circular FIFO of DEPTH entries, each holding {data, tag, decrypt}. Write and read pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0. Occupancy is a separate counter.
- Write: when in_valid=1 and the FIFO is not full, the block is stored at the write pointer and the write pointer increments.
- Full-write exception: when the FIFO is full but the head block's final word is handshaken in the same cycle, the write is still accepted and occupancy stays at DEPTH.
- Drop: when in_valid=1, the FIFO is full and no final-word handshake occurs, the block is discarded and overflow is set. overflow clears only on reset.
- Serializer: a 2-bit word counter wc selects out_data = head.data[127-32*wc -: 32], so word 0 is bits [127:96].
- A handshake is out_valid & out_ready. Each handshake increments wc. On the handshake with wc=3, wc returns to 0, the read pointer increments and occupancy decrements.
- out_valid = (occupancy != 0). out_last = out_valid & (wc == 3). out_tag and out_decrypt come from the head entry.
- While out_valid=1 and out_ready=0, out_data, out_last, out_tag and out_decrypt hold stable.
- Occupancy update per cycle: +1 on an accepted write, -1 on a final-word handshake, unchanged when both or neither occur.
- stall_req and occupancy are combinational from registered state only; no path from in_valid or out_ready.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, out_tag=0, out_decrypt=0, occupancy=0, stall_req=0 (given STALL_MARGIN < DEPTH), overflow=0. Pointers and wc reset to 0.
- Reset asserted mid-transfer discards all stored blocks and any partial serialization. After release, the first word out is word 0 of the next block written.
- Latency: a block written at edge N appears as out_valid=1 with word 0 on out_data after edge N (first-word fall-through, one cycle).
- Throughput: with out_ready held at 1, one word per cycle, so four cycles per block. Back-to-back blocks stream with no bubble.
- stall_req rises in the cycle after the write that brings occupancy to DEPTH-STALL_MARGIN. It falls in the cycle after the final-word handshake that drops occupancy below that threshold.
- Simultaneous write into an empty FIFO with no stored head: no handshake is possible that cycle; the block appears next cycle.

## Test plan
- Single block: write 128'h00112233_44556677_8899AABB_CCDDEEFF with tag 5 and out_ready=1. Required: words 00112233, 44556677, 8899AABB, CCDDEEFF on four consecutive cycles starting one cycle after the write, out_last only on the fourth, out_tag=5 throughout, occupancy back to 0.
- Backpressure: during word 1, hold out_ready=0 for 3 cycles. Required: out_data stays 44556677 and out_valid stays 1, and word 2 follows on the first cycle out_ready returns to 1.
- Stall threshold (DEPTH=16): write 5 blocks with out_ready=0. Required: stall_req=1 exactly when occupancy=5, and it clears after one complete block drains.
- Overflow and full exception: fill 16 blocks, then write a 17th with out_ready=0. Required: overflow=1 and the block is dropped. Then write one block in the same cycle as the head's word-3 handshake. Required: it is accepted, occupancy stays 16, and overflow is unchanged.
- Wrap-around: stream 40 blocks with incrementing tags and random out_ready. Required: all blocks emerge in order with intact data and tags, and overflow stays 0.
- Reset mid-block: assert rst after word 1 of a 3-block backlog. Required: all outputs return to reset values immediately, and after release a new block emerges starting at word 0.
